controller_table_loader: RTL and testbench

- Parametrised successor to the per-transducer table fetch in the controller (delay/filter/cycle sweeps).
- Reads NUM_TABLES tables of DEPTH entries each from the FPGA-side port of a controller BRAM, using a fully pipelined read with configurable latency.
- Fills a shadow array, then commits all tables to the outputs in a single cycle, so consumers never see a half-updated set.
- Sits between the CPU-written BRAMs and the per-transducer datapath. Sweeps are triggered by a REQ/ACK handshake from the main control FSM.

---
 rtl/controller_table_loader.sv | 209 ++++++++++++++++++++
 tb/tb_controller_table_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/controller_table_loader.sv
// controller_table_loader: sweeps NUM_TABLES tables of DEPTH entries out of a
// controller BRAM into a shadow array, then commits the whole set to TABLE_OUT
// in one cycle so the transducer datapath never sees a mixed set.
// Optional build macro CONTROLLER_TABLE_LOADER_CHECKSUM_EN adds a running XOR
// of every captured word, published on CHECKSUM at commit (tied to 0 otherwise).
module controller_table_loader #(
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 249,
  parameter int NUM_TABLES = 3,
  parameter int ADDR_W     = 11,
  parameter int READ_LAT   = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              UPDATE_REQ,
  output logic              UPDATE_ACK,
  output logic              BUSY,
  output logic [ADDR_W-1:0] BRAM_ADDR,
  input  logic [DATA_W-1:0] BRAM_DOUT,
  output logic [DATA_W-1:0] TABLE_OUT [NUM_TABLES*DEPTH],
  output logic [DATA_W-1:0] CHECKSUM
);

  localparam int         TOTAL  = NUM_TABLES * DEPTH;
  localparam int         IDX_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [7:0] I_LAST = 8'(DEPTH - 1);
  localparam logic [2:0] T_LAST = 3'(NUM_TABLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, COMMIT} state_e;

  state_e              state_q, state_d;
  logic                pending_q, pending_d;
  logic [2:0]          t_q, t_d;
  logic [7:0]          i_q, i_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   issue_addr;
  logic [READ_LAT-1:0] vld_q, vld_d;
  logic [IDX_W-1:0]    pidx_q [READ_LAT];
  logic [IDX_W-1:0]    pidx_d [READ_LAT];
  logic [DATA_W-1:0]   shadow_q [TOTAL];
  logic [DATA_W-1:0]   shadow_d [TOTAL];
  logic [DATA_W-1:0]   table_q  [TOTAL];
  logic [DATA_W-1:0]   table_d  [TOTAL];
  logic                issuing;
  logic                commit;
  logic                cap_vld;
  logic [IDX_W-1:0]    cap_idx;

  // Each table lives in its own 256-word segment: address = {t, i}.
  assign issue_addr = (ADDR_W'(t_q) << 8) | ADDR_W'(i_q);

  // Address goes out combinationally while issuing so the valid pipeline is
  // exactly READ_LAT deep; otherwise the last issued address is held.
  assign BRAM_ADDR  = issuing ? issue_addr : addr_q;
  assign UPDATE_ACK = (state_q == COMMIT);
  assign BUSY       = (state_q != IDLE);
  assign cap_vld    = vld_q[READ_LAT-1];
  assign cap_idx    = pidx_q[READ_LAT-1];

  // Next-state logic: sweep sequencing, counters and request coalescing.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    t_d       = t_q;
    i_d       = i_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    issuing   = 1'b0;
    commit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (UPDATE_REQ || pending_q) begin
          pending_d = 1'b0;
          t_d       = 3'd0;
          i_d       = 8'd0;
          idx_d     = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        issuing = 1'b1;
        addr_d  = issue_addr;
        idx_d   = idx_q + IDX_W'(1);
        if (i_q == I_LAST) begin
          i_d = 8'd0;
          t_d = t_q + 3'd1;
        end else begin
          i_d = i_q + 8'd1;
        end
        if ((i_q == I_LAST) && (t_q == T_LAST)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Shadow is complete once the last in-flight read has landed.
        if (vld_q == '0) begin
          commit  = 1'b1;
          state_d = COMMIT;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Any request seen while a sweep is in flight folds into one more sweep.
    if (UPDATE_REQ && (state_q != IDLE)) begin
      pending_d = 1'b1;
    end
  end

  // Read-latency pipeline carrying a valid bit and the flat entry index.
  always_comb begin
    vld_d[0]  = issuing;
    pidx_d[0] = idx_q;
    for (int k = 1; k < READ_LAT; k++) begin
      vld_d[k]  = vld_q[k-1];
      pidx_d[k] = pidx_q[k-1];
    end
  end

  // Shadow capture on returning reads; whole-set copy to the outputs at commit.
  always_comb begin
    for (int k = 0; k < TOTAL; k++) begin
      shadow_d[k] = shadow_q[k];
      if (cap_vld && (cap_idx == IDX_W'(k))) begin
        shadow_d[k] = BRAM_DOUT;
      end
      table_d[k] = commit ? shadow_q[k] : table_q[k];
    end
  end

  // Control registers; reset aborts any sweep in progress.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      t_q       <= 3'd0;
      i_q       <= 8'd0;
      idx_q     <= '0;
      addr_q    <= '0;
      vld_q     <= '0;
      for (int k = 0; k < READ_LAT; k++) pidx_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      t_q       <= t_d;
      i_q       <= i_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      vld_q     <= vld_d;
      for (int k = 0; k < READ_LAT; k++) pidx_q[k] <= pidx_d[k];
    end
  end

  // Shadow and committed table storage.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < TOTAL; k++) begin
        shadow_q[k] <= '0;
        table_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < TOTAL; k++) begin
        shadow_q[k] <= shadow_d[k];
        table_q[k]  <= table_d[k];
      end
    end
  end

  genvar gi;
  for (gi = 0; gi < TOTAL; gi++) begin : g_out
    assign TABLE_OUT[gi] = table_q[gi];
  end

`ifdef CONTROLLER_TABLE_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] csum_q, csum_d;

  // Running XOR cleared at sweep start, published together with the tables.
  always_comb begin
    acc_d  = acc_q;
    csum_d = csum_q;
    if ((state_q == IDLE) && (state_d == ISSUE)) begin
      acc_d = '0;
    end else if (cap_vld) begin
      acc_d = acc_q ^ BRAM_DOUT;
    end
    if (commit) begin
      csum_d = acc_q;
    end
  end

  // Checksum registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_q  <= '0;
      csum_q <= '0;
    end else begin
      acc_q  <= acc_d;
      csum_q <= csum_d;
    end
  end

  assign CHECKSUM = csum_q;
`else
  assign CHECKSUM = '0;
`endif

endmodule

// File: tb/tb_controller_table_loader.sv
// Directed bench for controller_table_loader: sweep latency and BUSY window,
// request coalescing, atomic commit, mid-sweep reset, READ_LAT corners and
// the optional checksum.
module tb_controller_table_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks = 0;
  int   errors = 0;

`ifdef CONTROLLER_TABLE_LOADER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- main instance: 3 x 249, READ_LAT 2 ----------------
  localparam int M_TOT = 747;
  localparam int M_LAT = 3 * 249 + 2 + 2;
  logic        m_req, m_ack, m_busy;
  logic [10:0] m_addr;
  logic [15:0] m_dout, m_csum;
  logic [15:0] m_tab [M_TOT];
  logic [15:0] m_mem [2048];
  logic [15:0] m_st  [2];

  always @(posedge clk) begin
    m_st[0] <= m_mem[m_addr];
    m_st[1] <= m_st[0];
  end
  assign m_dout = m_st[1];

  controller_table_loader #(.DATA_W(16), .DEPTH(249), .NUM_TABLES(3), .ADDR_W(11), .READ_LAT(2)) u_main (
    .CLK(clk), .RST(rst), .UPDATE_REQ(m_req), .UPDATE_ACK(m_ack), .BUSY(m_busy),
    .BRAM_ADDR(m_addr), .BRAM_DOUT(m_dout), .TABLE_OUT(m_tab), .CHECKSUM(m_csum));

  // ---------------- single-entry instances, READ_LAT 1/3/4 ----------------
  logic        s_req;
  logic        s1_ack, s1_busy, s3_ack, s3_busy, s4_ack, s4_busy;
  logic [10:0] s1_addr, s3_addr, s4_addr;
  logic [15:0] s1_csum, s3_csum, s4_csum;
  logic [15:0] s1_tab [1];
  logic [15:0] s3_tab [1];
  logic [15:0] s4_tab [1];
  logic [15:0] s1_st [4];
  logic [15:0] s3_st [4];
  logic [15:0] s4_st [4];

  always @(posedge clk) begin
    s1_st[0] <= (s1_addr == 11'd0) ? 16'h1234 : 16'hDEAD;
    s3_st[0] <= (s3_addr == 11'd0) ? 16'h1234 : 16'hDEAD;
    s4_st[0] <= (s4_addr == 11'd0) ? 16'h1234 : 16'hDEAD;
    for (int k = 1; k < 4; k++) begin
      s1_st[k] <= s1_st[k-1];
      s3_st[k] <= s3_st[k-1];
      s4_st[k] <= s4_st[k-1];
    end
  end

  controller_table_loader #(.DATA_W(16), .DEPTH(1), .NUM_TABLES(1), .ADDR_W(11), .READ_LAT(1)) u_s1 (
    .CLK(clk), .RST(rst), .UPDATE_REQ(s_req), .UPDATE_ACK(s1_ack), .BUSY(s1_busy),
    .BRAM_ADDR(s1_addr), .BRAM_DOUT(s1_st[0]), .TABLE_OUT(s1_tab), .CHECKSUM(s1_csum));
  controller_table_loader #(.DATA_W(16), .DEPTH(1), .NUM_TABLES(1), .ADDR_W(11), .READ_LAT(3)) u_s3 (
    .CLK(clk), .RST(rst), .UPDATE_REQ(s_req), .UPDATE_ACK(s3_ack), .BUSY(s3_busy),
    .BRAM_ADDR(s3_addr), .BRAM_DOUT(s3_st[2]), .TABLE_OUT(s3_tab), .CHECKSUM(s3_csum));
  controller_table_loader #(.DATA_W(16), .DEPTH(1), .NUM_TABLES(1), .ADDR_W(11), .READ_LAT(4)) u_s4 (
    .CLK(clk), .RST(rst), .UPDATE_REQ(s_req), .UPDATE_ACK(s4_ack), .BUSY(s4_busy),
    .BRAM_ADDR(s4_addr), .BRAM_DOUT(s4_st[3]), .TABLE_OUT(s4_tab), .CHECKSUM(s4_csum));

  // ---------------- checksum instance: 1 x 3, READ_LAT 2 ----------------
  logic        c_req, c_ack, c_busy;
  logic [10:0] c_addr;
  logic [15:0] c_csum;
  logic [15:0] c_tab [3];
  logic [15:0] c_st  [2];

  always @(posedge clk) begin
    case (c_addr)
      11'd0:   c_st[0] <= 16'h000F;
      11'd1:   c_st[0] <= 16'h00F0;
      11'd2:   c_st[0] <= 16'h0F00;
      default: c_st[0] <= 16'hDEAD;
    endcase
    c_st[1] <= c_st[0];
  end

  controller_table_loader #(.DATA_W(16), .DEPTH(3), .NUM_TABLES(1), .ADDR_W(11), .READ_LAT(2)) u_cs (
    .CLK(clk), .RST(rst), .UPDATE_REQ(c_req), .UPDATE_ACK(c_ack), .BUSY(c_busy),
    .BRAM_ADDR(c_addr), .BRAM_DOUT(c_st[1]), .TABLE_OUT(c_tab), .CHECKSUM(c_csum));

  // Run one main sweep from a single-cycle request; returns latency and BUSY cycles.
  task automatic main_sweep(output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = 0;
    m_req = 1'b1;
    for (int n = 1; n <= 1000 && lat == 0; n++) begin
      @(posedge clk); #1;
      m_req = 1'b0;
      if (m_busy) busy_cycles++;
      if (m_ack) lat = n;
    end
  endtask

  initial begin
    int lat, bc, nz, acks, first_ack, second_ack;
    int lat1, lat3, lat4, n1, n3, n4, lc, nc;
    logic [15:0] exp_csum, exp256;

    rst = 1'b1; m_req = 1'b0; s_req = 1'b0; c_req = 1'b0;
    for (int a = 0; a < 2048; a++) m_mem[a] = 16'h0;
    for (int t = 0; t < 3; t++)
      for (int i = 0; i < 249; i++)
        m_mem[(t << 8) | i] = 16'((t << 12) | i);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    chk("rst_busy", m_busy, 0);
    chk("rst_ack", m_ack, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_tab0", m_tab[0], 0);
    chk("rst_tab746", m_tab[746], 0);
    chk("rst_csum", m_csum, 0);
    $display("reset released");

    // READ_LAT corners with a single entry
    lat1 = 0; lat3 = 0; lat4 = 0; n1 = 0; n3 = 0; n4 = 0;
    s_req = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      s_req = 1'b0;
      if (s1_ack) begin n1++; if (lat1 == 0) lat1 = n; end
      if (s3_ack) begin n3++; if (lat3 == 0) lat3 = n; end
      if (s4_ack) begin n4++; if (lat4 == 0) lat4 = n; end
    end
    chk("lat_rl1", lat1, 4);
    chk("lat_rl3", lat3, 6);
    chk("lat_rl4", lat4, 7);
    chk("acks_rl1", n1, 1);
    chk("acks_rl3", n3, 1);
    chk("acks_rl4", n4, 1);
    chk("tab_rl1", s1_tab[0], 16'h1234);
    chk("tab_rl3", s3_tab[0], 16'h1234);
    chk("tab_rl4", s4_tab[0], 16'h1234);
    $display("single-entry sweeps: lat %0d/%0d/%0d", lat1, lat3, lat4);

    // checksum instance
    lc = 0;
    c_req = 1'b1;
    for (int n = 1; n <= 30 && lc == 0; n++) begin
      @(posedge clk); #1;
      c_req = 1'b0;
      if (c_ack) lc = n;
    end
    chk("lat_cs", lc, 7);
    chk("cs_tab0", c_tab[0], 16'h000F);
    chk("cs_tab1", c_tab[1], 16'h00F0);
    chk("cs_tab2", c_tab[2], 16'h0F00);
    chk("cs_value", c_csum, CSUM_ON ? 16'h0FFF : 16'h0000);
    $display("checksum sweep: checksum=%h", c_csum);

    // main sweep: latency, BUSY window, contents
    main_sweep(lat, bc);
    chk("sweep_lat", lat, M_LAT);
    chk("busy_cycles", bc, M_LAT);
    chk("tab_2_5", m_tab[2*249+5], 16'h2005);
    chk("tab_0_0", m_tab[0], 16'h0000);
    chk("tab_0_248", m_tab[248], 16'h00F8);
    chk("tab_1_0", m_tab[249], 16'h1000);
    chk("tab_1_7", m_tab[256], 16'h1007);
    chk("tab_2_248", m_tab[746], 16'h20F8);
    exp_csum = 16'h0;
    for (int t = 0; t < 3; t++)
      for (int i = 0; i < 249; i++)
        exp_csum = exp_csum ^ 16'((t << 12) | i);
    chk("main_csum", m_csum, CSUM_ON ? exp_csum : 16'h0000);
    @(posedge clk); #1;
    chk("busy_drop", m_busy, 0);
    chk("ack_single", m_ack, 0);
    $display("main sweep: lat=%0d busy=%0d", lat, bc);

    // coalescing + atomic commit: 1 + 3 requests, word (1,7) rewritten mid-sweep
    acks = 0; first_ack = -1; second_ack = -1; exp256 = 16'h1007;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      m_req = (cyc == 0 || cyc == 10 || cyc == 20 || cyc == 600);
      if (cyc == 400) m_mem[11'h107] = 16'hBEEF;
      @(posedge clk); #1;
      if (m_ack) begin
        acks++;
        if (acks == 1) begin first_ack = cyc; exp256 = 16'h1007; end
        else begin second_ack = cyc; exp256 = 16'hBEEF; end
        $display("commit %0d at cycle %0d", acks, cyc);
      end
      chk("hold_256", m_tab[256], exp256);
      chk("hold_503", m_tab[503], 16'h2005);
    end
    m_req = 1'b0;
    chk("coalesced_acks", acks, 2);
    chk("back_to_back_gap", second_ack - first_ack, M_LAT + 1);
    chk("new_1_7", m_tab[256], 16'hBEEF);
    exp_csum = exp_csum ^ 16'h1007 ^ 16'hBEEF;
    chk("csum_after_edit", m_csum, CSUM_ON ? exp_csum : 16'h0000);

    // reset during a sweep
    nc = 0;
    m_req = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      m_req = 1'b0;
      if (m_ack) nc++;
    end
    chk("mid_busy", m_busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", m_busy, 0);
    chk("abort_ack", m_ack, 0);
    chk("abort_addr", m_addr, 0);
    chk("abort_csum", m_csum, 0);
    nz = 0;
    for (int k = 0; k < M_TOT; k++) if (m_tab[k] != 16'h0) nz++;
    chk("abort_tab_nonzero", nz, 0);
    for (int n = 1; n <= 800; n++) begin
      @(posedge clk); #1;
      if (m_ack || m_busy) nc++;
    end
    chk("abort_no_ack", nc, 0);
    $display("sweep aborted by reset");

    main_sweep(lat, bc);
    chk("resweep_lat", lat, M_LAT);
    chk("resweep_1_7", m_tab[256], 16'hBEEF);
    chk("resweep_2_5", m_tab[503], 16'h2005);
    chk("resweep_csum", m_csum, CSUM_ON ? exp_csum : 16'h0000);
    $display("sweep after reset: lat=%0d", lat);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
